tape_ctrl: RTL and testbench

Data-tape controller for the Brainfuck core: accepts decoded tape commands (`+ - < > . ,`, run-length collapsed into an argument) from the execute stage and drives a single-port synchronous-read `bram_sp` holding the tape. It keeps the current cell cached in a register, so cell arithmetic and `[`/`]` zero tests never wait on the BRAM. Only pointer moves pay the one-cycle BRAM read latency. Sits between the instruction execute stage (upstream) and the tape `bram_sp` instance (downstream, instantiated by the parent).

---
 rtl/tape_pkg.sv | 23 ++
 rtl/tape_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tape_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// tape_pkg: shared types for the Brainfuck data-tape controller.
//   tape_op_e    - 3-bit tape command opcode issued by the execute stage
//                  (codes 6 and 7 are reserved and treated as NOP).
//   tape_state_e - controller FSM states.
package tape_pkg;

   typedef enum logic [2:0] {
      OpAdd   = 3'd0,
      OpSub   = 3'd1,
      OpRight = 3'd2,
      OpLeft  = 3'd3,
      OpRead  = 3'd4,
      OpWrite = 3'd5
   } tape_op_e;

   typedef enum logic [1:0] {
      StClear = 2'd0,
      StWait  = 2'd1,
      StLoad  = 2'd2,
      StIdle  = 2'd3
   } tape_state_e;

endpackage

// File: rtl/tape_ctrl.sv
// tape_ctrl: data-tape controller. Caches the current cell in a register so
// cell arithmetic and zero tests never wait on the tape BRAM; only pointer
// moves pay the BRAM read latency (WAIT then LOAD).
//
// Optional feature macro: TAPE_CLEAR_EN - after reset, sweep every tape cell
// to zero (one cell per cycle) before accepting commands. Without it, cell 0
// is loaded from whatever the BRAM already holds.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//   cmd_op, cmd_arg     - opcode (tape_op_e) and amount/value
//   rsp_valid, rsp_data - one-cycle READ response, cycle after accept
//   ptr, cell_zero      - current tape pointer, cached cell == 0
//   mem_we/addr/wdata   - single-port BRAM write side / address
//   mem_rdata           - BRAM registered read data (valid cycle after addr)
module tape_ctrl
   import tape_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_arg,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [ADDR_WIDTH-1:0] ptr,
   output logic                  cell_zero,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef TAPE_CLEAR_EN
   localparam tape_state_e StReset = StClear;
`else
   localparam tape_state_e StReset = StWait;
`endif

   tape_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] cur_q, cur_d;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rd_accept;
   tape_op_e              op;
   logic [ADDR_WIDTH-1:0] move_amt;

`ifdef TAPE_CLEAR_EN
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
`endif

   assign op       = tape_op_e'(cmd_op);
   // Zero-extend or truncate the argument to the pointer width.
   assign move_amt = ADDR_WIDTH'(cmd_arg);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cur_d     = cur_q;
      rd_accept = 1'b0;
      cmd_ready = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = ptr_q;
      mem_wdata = cur_q;
`ifdef TAPE_CLEAR_EN
      clr_cnt_d = clr_cnt_q;
`endif
      case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (op)
                  OpAdd: begin
                     cur_d  = cur_q + cmd_arg;
                     mem_we = 1'b1;
                  end
                  OpSub: begin
                     cur_d  = cur_q - cmd_arg;
                     mem_we = 1'b1;
                  end
                  OpWrite: begin
                     cur_d  = cmd_arg;
                     mem_we = 1'b1;
                  end
                  OpRight: begin
                     ptr_d   = ptr_q + move_amt;
                     state_d = StWait;
                  end
                  OpLeft: begin
                     ptr_d   = ptr_q - move_amt;
                     state_d = StWait;
                  end
                  OpRead:  rd_accept = 1'b1;
                  default: ;
               endcase
            end
            // Write-through keeps the BRAM copy of the cached cell current.
            mem_wdata = cur_d;
         end
         StWait: state_d = StLoad;
         StLoad: begin
            cur_d   = mem_rdata;
            state_d = StIdle;
         end
`ifdef TAPE_CLEAR_EN
         StClear: begin
            mem_addr  = clr_cnt_q;
            mem_we    = 1'b1;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
               ptr_d   = '0;
               cur_d   = '0;
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StWait;
      endcase
      // Nothing is accepted or written while reset is held.
      if (rst) begin
         cmd_ready = 1'b0;
         mem_we    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StReset;
         ptr_q       <= '0;
         cur_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
`ifdef TAPE_CLEAR_EN
         clr_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_q       <= cur_d;
         rsp_valid_q <= rd_accept;
         if (rd_accept) rsp_data_q <= cur_q;
`ifdef TAPE_CLEAR_EN
         clr_cnt_q   <= clr_cnt_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign ptr       = ptr_q;
   assign cell_zero = (cur_q == '0);

endmodule

// File: tb/tb_tape_ctrl.sv
// tb_tape_ctrl: self-checking bench for tape_ctrl (ADDR_WIDTH=4, DATA_WIDTH=8).
// A behavioural BRAM sits on the mem_* ports; the reference model is a plain
// integer tape array plus pointer, updated with modulo arithmetic.
module tb_tape_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int CELLS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [DW-1:0] cmd_arg;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] ptr;
   logic          cell_zero;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] bram [CELLS];
   int            ref_tape [CELLS];
   int            ref_ptr;
   int            n_cmp = 0;
   int            n_err = 0;

   typedef struct {
      int op;
      int arg;
      int exp_ptr;
      int exp_val;   // written value or READ response; -1 when not observable
   } vec_t;

   vec_t tbl [12];

   tape_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .ptr       (ptr),
      .cell_zero (cell_zero),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      // A pending WRITE during reset must not reach the BRAM.
      rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd5; cmd_arg = 8'h5a;
      #1;
      check("rst_we", int'(mem_we), 0);
      check("rst_ready", int'(cmd_ready), 0);
      @(negedge clk); #1;
      check("rst_we2", int'(mem_we), 0);
      check("rst_ready2", int'(cmd_ready), 0);
      @(negedge clk);
      rst = 1'b0; cmd_valid = 1'b0;
      #1;
      check("rst_ptr", int'(ptr), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_data", int'(rsp_data), 0);
      check("rst_ready_low", int'(cmd_ready), 0);
      ref_ptr = 0;
`ifdef TAPE_CLEAR_EN
      for (int i = 0; i < CELLS; i++) begin
         check("clr_we", int'(mem_we), 1);
         check("clr_addr", int'(mem_addr), i);
         check("clr_data", int'(mem_wdata), 0);
         check("clr_ready", int'(cmd_ready), 0);
         ref_tape[i] = 0;
         @(negedge clk); #1;
      end
`else
      check("init_wait_addr", int'(mem_addr), 0);
      check("init_wait_we", int'(mem_we), 0);
      @(negedge clk); #1;
      check("init_load_ready", int'(cmd_ready), 0);
      check("init_load_we", int'(mem_we), 0);
      @(negedge clk); #1;
`endif
      check("rst_done_ready", int'(cmd_ready), 1);
      check("rst_done_ptr", int'(ptr), 0);
      check("rst_done_zero", int'(cell_zero), int'(ref_tape[0] == 0));
   endtask

   task automatic issue(input int op, input int arg, output int obs);
      int n;
      int cur;
      int nv;
      bit is_wr;
      bit is_mv;
      obs = -1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      if (cmd_ready !== 1'b1) begin
         check("ready_timeout", 0, 1);
         return;
      end
      cmd_valid = 1'b1; cmd_op = op[2:0]; cmd_arg = arg[DW-1:0];
      #1;
      cur   = ref_tape[ref_ptr];
      is_wr = (op == 0) || (op == 1) || (op == 5);
      is_mv = (op == 2) || (op == 3);
      if (is_wr) begin
         if (op == 0)      nv = (cur + arg) % 256;
         else if (op == 1) nv = (cur - arg + 256) % 256;
         else              nv = arg;
         check("wr_we", int'(mem_we), 1);
         check("wr_addr", int'(mem_addr), ref_ptr);
         check("wr_data", int'(mem_wdata), nv);
         obs = int'(mem_wdata);
         ref_tape[ref_ptr] = nv;
      end else begin
         check("nowr_we", int'(mem_we), 0);
         check("idle_addr", int'(mem_addr), ref_ptr);
      end
      if (op == 2) ref_ptr = (ref_ptr + arg) % CELLS;
      if (op == 3) ref_ptr = (ref_ptr - (arg % CELLS) + CELLS) % CELLS;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      check("rsp_valid", int'(rsp_valid), int'(op == 4));
      if (op == 4) begin
         check("rsp_data", int'(rsp_data), cur);
         obs = int'(rsp_data);
      end
      if (is_mv) begin
         check("wait_ready", int'(cmd_ready), 0);
         check("wait_addr", int'(mem_addr), ref_ptr);
         check("wait_we", int'(mem_we), 0);
         @(negedge clk); #1;
         check("load_ready", int'(cmd_ready), 0);
         check("load_we", int'(mem_we), 0);
         @(negedge clk); #1;
         check("move_done_ready", int'(cmd_ready), 1);
      end
      check("ptr", int'(ptr), ref_ptr);
      check("cell_zero", int'(cell_zero), int'(ref_tape[ref_ptr] == 0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int obs;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
      for (int i = 0; i < CELLS; i++) begin
         bram[i]     = DW'($urandom);
         ref_tape[i] = int'(bram[i]);
      end
      ref_ptr = 0;
      @(negedge clk);
      do_reset();

      tbl[0]  = '{5, 8'h00, 0, 8'h00};
      tbl[1]  = '{0, 3,     0, 3};
      tbl[2]  = '{0, 255,   0, 2};
      tbl[3]  = '{4, 0,     0, 2};
      tbl[4]  = '{5, 8'h41, 0, 8'h41};
      tbl[5]  = '{2, 1,     1, -1};
      tbl[6]  = '{5, 7,     1, 7};
      tbl[7]  = '{3, 1,     0, -1};
      tbl[8]  = '{4, 0,     0, 8'h41};
      tbl[9]  = '{1, 8'h41, 0, 0};
      tbl[10] = '{1, 1,     0, 255};
      tbl[11] = '{0, 1,     0, 0};
      for (int i = 0; i < 12; i++) begin
         issue(tbl[i].op, tbl[i].arg, obs);
         check("tbl_ptr", int'(ptr), tbl[i].exp_ptr);
         if (tbl[i].exp_val >= 0) check("tbl_val", obs, tbl[i].exp_val);
      end
      check("tbl_end_zero", int'(cell_zero), 1);

      // Pointer wrap below zero, then read back the wrapped cell.
      issue(3, 1, obs);
      check("left_wrap", int'(ptr), CELLS - 1);
      issue(4, 0, obs);
      // Reserved opcodes and a zero-length move.
      issue(6, 8'hff, obs);
      issue(7, 8'h12, obs);
      issue(2, 0, obs);
      check("move0_ptr", int'(ptr), CELLS - 1);

      for (int k = 0; k < 300; k++) begin
         issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), obs);
      end

      // Reset in the WAIT cycle of RIGHT 5.
      while (cmd_ready !== 1'b1) @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd2; cmd_arg = 8'd5;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      check("mid_wait_ptr", int'(ptr), (ref_ptr + 5) % CELLS);
      do_reset();
      issue(4, 0, obs);

`ifdef TAPE_CLEAR_EN
      // Reset partway through the sweep restarts it at cell 0.
      issue(5, 8'h99, obs);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      do_reset();
      issue(4, 0, obs);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
